per2axi_req_arbiter: RTL

- N-way round-robin arbiter that shares one per2axi request buffer between several peripheral-side requesters.
- Grants one requester at a time and holds the grant across stalls and multi-beat bursts, so beats from different requesters never interleave.
- Tags each forwarded beat with the source index for response routing.
- Sits between the cluster peripheral ports and the per2axi request buffer input.

---
 rtl/per2axi_pkg.sv | 15 +
 rtl/per2axi_rr_prio.sv | 31 +++
 rtl/per2axi_req_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/per2axi_pkg.sv
// Types and helpers shared by the per2axi request/response buffers and arbiters.
package per2axi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  // Index width for n entries; never below one bit so a 1-entry id still exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/per2axi_rr_prio.sv
// Rotating priority encoder: first set request at or after rr_ptr_i, wrapping.
module per2axi_rr_prio
  import per2axi_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic [W-1:0] id_o,
  output logic         found_o
);

  int k;

  // Scan from the farthest offset down so the nearest one to rr_ptr_i wins.
  always_comb begin
    id_o    = '0;
    found_o = 1'b0;
    k       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(rr_ptr_i) + i;
      if (k >= N) k = k - N;
      if (req_i[k]) begin
        id_o    = W'(k);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/per2axi_req_arbiter.sv
// Round-robin arbiter sharing the per2axi request buffer; locks a grant across
// stalls and bursts so beats from different requesters never interleave.
module per2axi_req_arbiter
  import per2axi_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LOG_N_REQ  = idx_width(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]            req_last_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        out_valid_o,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic                        out_last_o,
  output logic [LOG_N_REQ-1:0]        out_id_o,
  input  logic                        out_ready_i,
  output logic                        burst_err_o,
  output arb_state_t                  state_o,
  output logic [LOG_N_REQ-1:0]        rr_ptr_o
);

  // Handshake: a beat moves when out_valid_o && out_ready_i; the requester keeps
  // valid and data stable until its ready bit is seen high.

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t           state_q;
  logic [LOG_N_REQ-1:0] rr_ptr_q;
  logic [LOG_N_REQ-1:0] gnt_id_q;
  logic [CNT_W-1:0]     beat_cnt_q;
  logic                 burst_err_q;

  logic [LOG_N_REQ-1:0] prio_id;
  logic                 prio_found;
  logic [LOG_N_REQ-1:0] id;
  logic [LOG_N_REQ-1:0] rr_next;
  logic                 grant_active;
  logic                 hs;

  per2axi_rr_prio #(
    .N (N_REQ),
    .W (LOG_N_REQ)
  ) u_rr_prio (
    .req_i    (req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .id_o     (prio_id),
    .found_o  (prio_found)
  );

  always_comb begin
    id           = (state_q == IDLE) ? prio_id : gnt_id_q;
    grant_active = (state_q != IDLE) || prio_found;
    out_valid_o  = req_valid_i[id];
    out_data_o   = req_data_i[id*DATA_WIDTH +: DATA_WIDTH];
    out_last_o   = req_last_i[id];
    out_id_o     = id;
    req_ready_o  = '0;
    if (grant_active) req_ready_o[id] = out_ready_i;
    hs           = out_valid_o && out_ready_i;
    rr_next      = (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      burst_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (prio_found) begin
            if (!hs) begin
              state_q  <= HOLD;
              gnt_id_q <= id;
            end else if (out_last_o) begin
              rr_ptr_q <= rr_next;
            end else if (MAX_BURST == 1) begin
              rr_ptr_q    <= rr_next;
              burst_err_q <= 1'b1;
            end else begin
              state_q    <= BURST;
              gnt_id_q   <= id;
              beat_cnt_q <= CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (hs) begin
            if (out_last_o) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_next;
            end else if (MAX_BURST == 1) begin
              state_q     <= IDLE;
              rr_ptr_q    <= rr_next;
              burst_err_q <= 1'b1;
            end else begin
              state_q    <= BURST;
              beat_cnt_q <= CNT_W'(1);
            end
          end
        end
        BURST: begin
          if (hs) begin
            if (out_last_o) begin
              state_q    <= IDLE;
              rr_ptr_q   <= rr_next;
              beat_cnt_q <= '0;
            end else if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
              // Burst ran to the cap without last: drop the lock so others progress.
              state_q     <= IDLE;
              rr_ptr_q    <= rr_next;
              beat_cnt_q  <= '0;
              burst_err_q <= 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign burst_err_o = burst_err_q;
  assign state_o     = state_q;
  assign rr_ptr_o    = rr_ptr_q;

endmodule
